// File: rtl/lbist_pkg.sv
// Shared constants and FSM state type for the LBIST pattern source.
package lbist_pkg;

    localparam int          LBIST_WIDTH        = 8;
    localparam logic [7:0]  LBIST_POLY         = 8'hB8;
    localparam logic [7:0]  LBIST_SEED_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_PRESENT,
        ST_DONE
    } lbist_state_e;

endpackage

// File: rtl/lbist_lfsr.sv
// Right-shifting Galois LFSR with synchronous load and step enable.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int               WIDTH        = LBIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(LBIST_POLY),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(LBIST_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED_DEFAULT;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= q[0] ? ((q >> 1) ^ POLY) : (q >> 1);
        end
    end

endmodule

// File: rtl/lbist_pattern_source.sv
// LBIST stimulus/capture: drives LFSR patterns into the CUT and hands each
// pattern/response pair downstream over valid/ready for a fixed session budget.
module lbist_pattern_source
    import lbist_pkg::*;
#(
    parameter int               WIDTH        = LBIST_WIDTH,
    parameter int               NUM_PATTERNS = 255,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(LBIST_POLY),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(LBIST_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] cut_stim,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pat_cnt
);

    lbist_state_e     state;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] seed_clean;
    logic             idle_like;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_seed;
    logic             lfsr_step;
    logic             last_pat;

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    assign seed_clean = (seed == '0) ? SEED_DEFAULT : seed;
    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
    assign lfsr_load  = idle_like && start;
    assign lfsr_seed  = seed_load ? seed_clean : seed_reg;
    assign lfsr_step  = (state == ST_PRESENT) && sig_valid && sig_ready;
    assign last_pat   = (pat_cnt + 8'd1) == 8'(NUM_PATTERNS);

    lbist_lfsr #(
        .WIDTH        (WIDTH),
        .POLY         (POLY),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (lfsr_seed),
        .step (lfsr_step),
        .q    (cut_stim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            seed_reg  <= SEED_DEFAULT;
            sig_in    <= '0;
            sig_out   <= '0;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (seed_load) seed_reg <= seed_clean;
                    if (start) begin
                        pat_cnt <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    sig_in    <= cut_stim;
                    sig_out   <= cut_resp;
                    sig_valid <= 1'b1;
                    state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (sig_ready) begin
                        sig_valid <= 1'b0;
                        pat_cnt   <= pat_cnt + 8'd1;
                        if (last_pat) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbist_pattern_source.sv
// Bench for lbist_pattern_source: a 4-pattern instance for session/handshake
// behaviour and a 255-pattern instance for full LFSR period coverage.
module tb_lbist_pattern_source;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       sig_ready_a = 1'b0, sig_ready_b = 1'b0;
    logic [7:0] mask_a = 8'hFF;

    logic [7:0] cut_stim_a, cut_resp_a, sig_in_a, sig_out_a, pat_cnt_a;
    logic       sig_valid_a, busy_a, done_a;
    logic [7:0] cut_stim_b, cut_resp_b, sig_in_b, sig_out_b, pat_cnt_b;
    logic       sig_valid_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] seed_model = 8'h01;

    assign cut_resp_a = cut_stim_a ^ mask_a;
    assign cut_resp_b = cut_stim_b ^ 8'h3C;

    always #5 clk = ~clk;

    lbist_pattern_source #(.NUM_PATTERNS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed_load(seed_load), .seed(seed),
        .cut_stim(cut_stim_a), .cut_resp(cut_resp_a), .sig_in(sig_in_a), .sig_out(sig_out_a),
        .sig_valid(sig_valid_a), .sig_ready(sig_ready_a), .busy(busy_a), .done(done_a),
        .pat_cnt(pat_cnt_a)
    );

    lbist_pattern_source #(.NUM_PATTERNS(255)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed_load(seed_load), .seed(seed),
        .cut_stim(cut_stim_b), .cut_resp(cut_resp_b), .sig_in(sig_in_b), .sig_out(sig_out_b),
        .sig_valid(sig_valid_b), .sig_ready(sig_ready_b), .busy(busy_b), .done(done_b),
        .pat_cnt(pat_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return (x >> 1) ^ ((x % 2) == 1 ? 8'hB8 : 8'h00);
    endfunction

    // One 4-pattern session on instance A, checked cycle by cycle against the model.
    task automatic run_a(input bit ld, input logic [7:0] ld_val, input bit rnd, input bit inject);
        logic [7:0] pat, last;
        int k = 0, cyc = 0, stall = 0;
        bit was_valid = 0, injected = 0, rdy;
        @(negedge clk);
        if (ld) begin
            seed_load  = 1'b1;
            seed       = ld_val;
            seed_model = (ld_val == 8'h00) ? 8'h01 : ld_val;
        end
        start_a     = 1'b1;
        sig_ready_a = 1'b0;
        @(posedge clk); @(negedge clk);
        start_a = 1'b0; seed_load = 1'b0;
        chk("apply_busy",  32'(busy_a), 1);
        chk("apply_valid", 32'(sig_valid_a), 0);
        chk("start_done",  32'(done_a), 0);
        chk("start_cnt",   32'(pat_cnt_a), 0);
        chk("apply_stim",  32'(cut_stim_a), 32'(seed_model));
        pat  = seed_model;
        last = pat;
        while (k < 4 && cyc < 400) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            start_a = 1'b0; seed_load = 1'b0;
            if (cyc == 1) chk("latency", 32'(sig_valid_a), 1);
            if (was_valid) chk("hold_valid", 32'(sig_valid_a), 1);
            if (sig_valid_a) begin
                chk("sig_in",   32'(sig_in_a),   32'(pat));
                chk("sig_out",  32'(sig_out_a),  32'(pat ^ mask_a));
                chk("pat_cnt",  32'(pat_cnt_a),  k);
                chk("stim_hold", 32'(cut_stim_a), 32'(pat));
                chk("busy",     32'(busy_a), 1);
                rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rnd && k == 1 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end
                sig_ready_a = rdy;
                was_valid   = !rdy;
                if (rdy) begin
                    last = pat;
                    pat  = lfsr_next(pat);
                    k++;
                end
            end else begin
                chk("gap_stim", 32'(cut_stim_a), 32'(pat));
                chk("gap_cnt",  32'(pat_cnt_a), k);
                was_valid   = 1'b0;
                sig_ready_a = 1'($urandom_range(0, 1));
            end
            if (inject && k == 2 && !injected) begin
                start_a = 1'b1; seed_load = 1'b1; seed = 8'h5A;
                injected = 1'b1;
            end
        end
        chk("no_timeout", k, 4);
        @(posedge clk); @(negedge clk);
        sig_ready_a = 1'b0;
        if (!rnd) chk("cycles", cyc + 1, 8);
        repeat (2) begin
            chk("done",      32'(done_a), 1);
            chk("done_busy", 32'(busy_a), 0);
            chk("done_vld",  32'(sig_valid_a), 0);
            chk("done_cnt",  32'(pat_cnt_a), 4);
            chk("done_in",   32'(sig_in_a), 32'(last));
            chk("done_out",  32'(sig_out_a), 32'(last ^ mask_a));
            chk("done_stim", 32'(cut_stim_a), 32'(pat));
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] pat;
        bit seen [256];
        int distinct = 0, cyc = 0, k = 0;

        repeat (3) @(negedge clk);
        chk("rst_vld",  32'(sig_valid_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_cnt",  32'(pat_cnt_a), 0);
        chk("rst_stim", 32'(cut_stim_a), 8'h01);
        chk("rst_in",   32'(sig_in_a), 0);
        chk("rst_out",  32'(sig_out_a), 0);
        rst = 1'b1;

        // Full-period session on B, seed = reset default.
        @(negedge clk);
        start_b = 1'b1; sig_ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        pat = 8'h01;
        while (k < 255 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sig_valid_b) begin
                chk("b_in",  32'(sig_in_b),  32'(pat));
                chk("b_out", 32'(sig_out_b), 32'(pat ^ 8'h3C));
                if (sig_in_b != 8'h00 && !seen[sig_in_b]) distinct++;
                seen[sig_in_b] = 1'b1;
                pat = lfsr_next(pat);
                k++;
            end
        end
        @(negedge clk);
        sig_ready_b = 1'b0;
        chk("b_distinct", distinct, 255);
        chk("b_done",     32'(done_b), 1);
        chk("b_cnt",      32'(pat_cnt_b), 255);
        chk("b_stim",     32'(cut_stim_b), 8'h01);

        mask_a = 8'hFF;
        run_a(0, 8'h00, 0, 0);
        mask_a = 8'($urandom);
        run_a(1, 8'h00, 1, 0);
        run_a(1, 8'($urandom_range(1, 255)), 1, 1);
        run_a(0, 8'h00, 1, 0);

        // Seed load on its own, start in a later cycle.
        @(negedge clk);
        seed_load = 1'b1; seed = 8'($urandom); seed_model = (seed == 8'h00) ? 8'h01 : seed;
        @(negedge clk);
        seed_load = 1'b0;
        repeat (3) begin
            mask_a = 8'($urandom);
            run_a(0, 8'h00, 1, 0);
            run_a(1, 8'($urandom), 1, 0);
        end

        // Reset in the middle of a session while a pair is pending.
        @(negedge clk);
        seed_load = 1'b1; seed = 8'h77; start_a = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start_a = 1'b0;
        @(negedge clk);
        sig_ready_a = 1'b1;
        @(negedge clk);
        sig_ready_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_vld", 32'(sig_valid_a), 1);
        chk("pre_rst_cnt", 32'(pat_cnt_a), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_vld",  32'(sig_valid_a), 0);
        chk("mid_rst_busy", 32'(busy_a), 0);
        chk("mid_rst_done", 32'(done_a), 0);
        chk("mid_rst_doneb", 32'(done_b), 0);
        chk("mid_rst_stim", 32'(cut_stim_a), 8'h01);
        chk("mid_rst_cnt",  32'(pat_cnt_a), 0);
        chk("mid_rst_in",   32'(sig_in_a), 0);
        @(negedge clk);
        rst = 1'b1;
        seed_model = 8'h01;
        run_a(0, 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
